// File: rtl/vec_compress_pkg.sv
// Shared types for vec_compress: FSM state enum, lane typedef and count-width helper.
// FIXPOINT_WIDTH defaults to 16 bits when the build does not supply it.
`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 16
`endif

package vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } vec_compress_state_t;

  typedef logic [`FIXPOINT_WIDTH-1:0] fixpoint_lane_t;

  // Wide enough to hold VEC_SIZE itself when every lane is active.
  function automatic int lane_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vec_compress_if.sv
// Request/result bundle for vec_compress; master drives the request, slave returns the packed result.
`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 16
`endif

interface vec_compress_if
  import vec_pkg::*;
#(
  parameter int VEC_SIZE = 16
);
  localparam int CNT_W = lane_cnt_w(VEC_SIZE);

  logic                          i_start;
  logic [VEC_SIZE-1:0]           i_mask;
  fixpoint_lane_t [VEC_SIZE-1:0] i_vec;
  logic                          o_busy;
  logic                          o_done;
  fixpoint_lane_t [VEC_SIZE-1:0] o_vec;
  logic [CNT_W-1:0]              o_count;

  modport slave (
    input  i_start, i_mask, i_vec,
    output o_busy, o_done, o_vec, o_count
  );

  modport master (
    output i_start, i_mask, i_vec,
    input  o_busy, o_done, o_vec, o_count
  );
endinterface

// File: rtl/vec_compress.sv
// Packs mask-selected lanes into the low output lanes, one source lane examined per cycle.
// VEC_COMPRESS_EARLY_EXIT_EN ends the scan once no active lanes remain; default scans all lanes.
`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 16
`endif

module vec_compress
  import vec_pkg::*;
#(
  parameter int VEC_SIZE = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  vec_compress_if.slave io_bus
);
  localparam int CNT_W = lane_cnt_w(VEC_SIZE);
  localparam int IDX_W = $clog2(VEC_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);

  vec_compress_state_t           r_state;
  vec_compress_state_t           w_state_nxt;
  logic [IDX_W-1:0]              r_idx;
  logic [IDX_W-1:0]              r_wptr;
  logic [CNT_W-1:0]              r_count;
  logic [VEC_SIZE-1:0]           r_mask;
  logic [VEC_SIZE-1:0]           w_mask_upd;
  fixpoint_lane_t [VEC_SIZE-1:0] r_vec;
  fixpoint_lane_t [VEC_SIZE-1:0] r_out;
  logic                          w_scan_end;

  always_comb begin
    w_mask_upd        = r_mask;
    w_mask_upd[r_idx] = 1'b0;
  end

`ifdef VEC_COMPRESS_EARLY_EXIT_EN
  assign w_scan_end = (r_idx == LAST_IDX) || (w_mask_upd == '0);
`else
  assign w_scan_end = (r_idx == LAST_IDX);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (io_bus.i_start) w_state_nxt = SCAN;
      SCAN:    if (w_scan_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // The write pointer may wrap after the final write of an all-ones mask; no write follows it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_mask  <= '0;
      r_vec   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.i_start) begin
            r_mask  <= io_bus.i_mask;
            r_vec   <= io_bus.i_vec;
            r_out   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_wptr  <= '0;
          end
        end
        SCAN: begin
          if (r_mask[r_idx]) begin
            r_out[r_wptr] <= r_vec[r_idx];
            r_wptr        <= r_wptr + 1'b1;
            r_count       <= r_count + 1'b1;
          end
          r_mask <= w_mask_upd;
          r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.o_busy  = (r_state == SCAN);
  assign io_bus.o_done  = (r_state == DONE);
  assign io_bus.o_vec   = r_out;
  assign io_bus.o_count = r_count;

endmodule
